// File: rtl/ts_channel_monitor.sv
// MPEG2-TS per-channel input monitor: 0x47 packet alignment, signal presence, saturating error count.
// Define TS_TEI_CHECK_EN to also count transport-error-indicator bits as errors while locked.
//   state     | meaning
//   ST_HUNT   | searching for any 0x47 byte
//   ST_VERIFY | candidate alignment, confirming sync bytes at packet spacing
//   ST_LOCKED | aligned; missed sync bytes are counted as errors
module ts_channel_monitor #(
    parameter int PKT_LEN  = 188,
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 3,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       clr_count,
    output logic       sync,
    output logic       valid,
    output logic [7:0] err_count
);
    localparam int         POS_W     = $clog2(PKT_LEN);
    localparam int         LOCK_W    = $clog2(LOCK_N + 1);
    localparam int         MISS_W    = $clog2(UNLOCK_N + 1);
    localparam logic [7:0] SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    logic [POS_W-1:0]    r_pos;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic [15:0]         r_idle;
    logic                r_sync;
    logic                r_valid;
    logic [7:0]          r_err_count;

    logic                w_is_sync;
    logic                w_pos_zero;
    logic [POS_W-1:0]    w_pos_inc;
    logic [15:0]         w_idle_next;
    logic                w_timeout;
    logic                w_sync_miss;
    logic                w_tei_err;
    logic                w_err_evt;

    assign w_is_sync   = (byte_data == SYNC_BYTE);
    assign w_pos_zero  = (r_pos == '0);
    assign w_pos_inc   = (r_pos == POS_W'(PKT_LEN - 1)) ? '0 : r_pos + POS_W'(1);
    assign w_idle_next = (r_idle == 16'(TIMEOUT)) ? r_idle : r_idle + 16'd1;
    assign w_timeout   = !byte_valid && (w_idle_next == 16'(TIMEOUT));
    assign w_sync_miss = byte_valid && (r_state == ST_LOCKED) && w_pos_zero && !w_is_sync;

`ifdef TS_TEI_CHECK_EN
    assign w_tei_err   = byte_valid && (r_state == ST_LOCKED) && (r_pos == POS_W'(1)) && byte_data[7];
`else
    assign w_tei_err   = 1'b0;
`endif

    assign w_err_evt   = w_sync_miss || w_tei_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_pos      <= '0;
            r_lock_cnt <= '0;
            r_miss_cnt <= '0;
            r_idle     <= '0;
            r_sync     <= 1'b0;
            r_valid    <= 1'b0;
        end else if (byte_valid) begin
            r_idle  <= '0;
            r_valid <= 1'b1;
            case (r_state)
                ST_HUNT: begin
                    if (w_is_sync) begin
                        r_state    <= ST_VERIFY;
                        r_lock_cnt <= LOCK_W'(1);
                        r_pos      <= POS_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (!w_pos_zero) begin
                        r_pos <= w_pos_inc;
                    end else if (w_is_sync) begin
                        r_pos      <= w_pos_inc;
                        r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
                        if (r_lock_cnt == LOCK_W'(LOCK_N - 1)) begin
                            r_state    <= ST_LOCKED;
                            r_sync     <= 1'b1;
                            r_miss_cnt <= '0;
                        end
                    end else begin
                        // The failing byte is consumed here, not re-examined by HUNT.
                        r_state    <= ST_HUNT;
                        r_lock_cnt <= '0;
                        r_pos      <= '0;
                    end
                end
                ST_LOCKED: begin
                    r_pos <= w_pos_inc;
                    if (w_pos_zero) begin
                        if (w_is_sync) begin
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt == MISS_W'(UNLOCK_N - 1)) begin
                            r_state    <= ST_HUNT;
                            r_sync     <= 1'b0;
                            r_miss_cnt <= '0;
                            r_lock_cnt <= '0;
                            r_pos      <= '0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                    r_sync  <= 1'b0;
                    r_pos   <= '0;
                end
            endcase
        end else begin
            r_idle <= w_idle_next;
            if (w_timeout) begin
                r_valid    <= 1'b0;
                r_state    <= ST_HUNT;
                r_sync     <= 1'b0;
                r_pos      <= '0;
                r_lock_cnt <= '0;
                r_miss_cnt <= '0;
            end
        end
    end

    // Clear has priority over a coincident error; the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_count) begin
            r_err_count <= '0;
        end else if (w_err_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign sync      = r_sync;
    assign valid     = r_valid;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_ts_channel_monitor.sv
// Directed self-checking bench for ts_channel_monitor; a short-packet instance covers error saturation.
`timescale 1ns/1ps
module tb_ts_channel_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       clr_count;
    logic       sync, valid;
    logic [7:0] err_count;
    logic       s_sync, s_valid;
    logic [7:0] s_err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err;

    localparam int SPKT = 8;

    ts_channel_monitor dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .clr_count(clr_count), .sync(sync), .valid(valid), .err_count(err_count)
    );

    ts_channel_monitor #(.PKT_LEN(SPKT)) u_sat (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .clr_count(clr_count), .sync(s_sync), .valid(s_valid), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb(input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Remaining n-1 bytes of a packet: byte 1 = b1, optional 0x47 at mid_idx, optional 1-clock gaps.
    task automatic body(input int n, input logic [7:0] b1, input int mid_idx, input bit gap);
        for (int i = 1; i < n; i++) begin
            sb((i == 1) ? b1 : ((i == mid_idx) ? 8'h47 : 8'h00));
            if (gap) idle(1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; clr_count = 1'b0;
        #2;
        do_reset();
        check("rst_sync", sync, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err_count, 0);

        // Clean lock: packet 1 has a mid-packet 0x47, packet 2 is gapped
        sb(8'h47);
        check("valid_rise", valid, 1);
        check("verify_sync0", sync, 0);
        body(188, 8'h00, 100, 1'b0);
        sb(8'h47);
        check("pkt2_sync0", sync, 0);
        body(188, 8'h00, 0, 1'b1);
        sb(8'h47);
        check("lock_sync1", sync, 1);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47); body(188, 8'h00, 0, 1'b0);
        check("clean_err0", err_count, 0);
        check("clean_sync", sync, 1);

        // Single misses separated by a clean sync keep the lock
        sb(8'h00);
        check("miss1_err", err_count, 1);
        check("miss1_sync", sync, 1);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47); body(188, 8'h00, 0, 1'b0);
        sb(8'h00); body(188, 8'h00, 0, 1'b0);
        sb(8'h00);
        check("miss_reset_sync", sync, 1);
        check("miss_reset_err", err_count, 3);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47); body(188, 8'h00, 0, 1'b0);

        // Three consecutive misses lose lock
        sb(8'h00); body(188, 8'h00, 0, 1'b0);
        sb(8'h00);
        check("miss2_sync", sync, 1);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h00);
        check("unlock_sync", sync, 0);
        check("unlock_err", err_count, 6);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47);
        check("relock1_sync", sync, 0);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47);
        check("relock2_sync", sync, 0);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47);
        check("relock3_sync", sync, 1);
        body(188, 8'h00, 0, 1'b0);

        // TEI bit in byte 1 while locked
        exp_err = 6;
`ifdef TS_TEI_CHECK_EN
        exp_err = 7;
`endif
        sb(8'h47); body(188, 8'h80, 0, 1'b0);
        check("tei_err", err_count, exp_err);
        check("tei_sync", sync, 1);

        // Presence timeout
        idle(1023);
        check("idle1023_valid", valid, 1);
        check("idle1023_sync", sync, 1);
        idle(1);
        check("timeout_valid", valid, 0);
        check("timeout_sync", sync, 0);
        check("timeout_err", err_count, exp_err);
        idle(5);
        check("timeout_hold", valid, 0);
        sb(8'h00);
        check("revalid", valid, 1);
        check("revalid_sync", sync, 0);

        // Saturation and clear on the short-packet instance
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sb(8'h47); body(SPKT, 8'h00, 0, 1'b0);
        end
        check("sat_lock", s_sync, 1);
        for (int g = 0; g < 150; g++) begin
            sb(8'h00); body(SPKT, 8'h00, 0, 1'b0);
            sb(8'h00); body(SPKT, 8'h00, 0, 1'b0);
            sb(8'h47); body(SPKT, 8'h00, 0, 1'b0);
            if (g == 126) check("sat_254", s_err_count, 254);
        end
        check("sat_255", s_err_count, 255);
        check("sat_sync", s_sync, 1);
        clr_count = 1'b1;
        sb(8'h00);
        clr_count = 1'b0;
        check("clr_wins", s_err_count, 0);
        body(SPKT, 8'h00, 0, 1'b0);
        sb(8'h00);
        check("post_clr_err", s_err_count, 1);
        check("post_clr_sync", s_sync, 1);

        // Async reset mid-acquisition forces a full re-acquisition
        do_reset();
        sb(8'h47); body(188, 8'h00, 0, 1'b0);
        sb(8'h47); body(50, 8'h00, 0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_err", s_err_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb(8'h47);
        check("reacq1_sync", sync, 0);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47);
        check("reacq2_sync", sync, 0);
        body(188, 8'h00, 0, 1'b0);
        sb(8'h47);
        check("reacq3_sync", sync, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
